instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache; the responder for the fetcher's instruction request interface (ins_asked / ins_addr in, ic_rdy / ins out).
- On a hit, returns the 32-bit instruction word one cycle after the request is sampled.
- On a miss, refills a whole line word-by-word through the memory controller, then responds.
- Supports a flush input, so a request made obsolete by a mispredict produces no response.

Parameters:
- INDEX_BITS, 6, number of lines is 2**INDEX_BITS.
- OFFSET_BITS, 2, words per line is 2**OFFSET_BITS.
- TAG_BITS, 32-2-OFFSET_BITS-INDEX_BITS (derived, 22 at defaults), tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (low = reset, sampled on posedge clk).
- rdy  in  1  global enable; when low, all state and outputs hold.
- ins_asked  in  1  fetcher request valid.
- ins_addr  in  32  fetch address, word aligned; bits [1:0] ignored.
- ic_rdy  out  1  one-cycle pulse: ins is valid.
- ins  out  32  instruction word for the accepted request.
- flush  in  1  discard any outstanding request (mispredict recovery).
- mc_ask  out  1  refill word request to memory controller.
- mc_addr  out  32  word address of refill request, bits [1:0]=0.
- mc_rdy  in  1  one-cycle pulse: mc_data valid for current mc_addr.
- mc_data  in  32  refill word.

Behaviour:
- Address split: tag = addr[31:2+OFFSET_BITS+INDEX_BITS]; index = addr[2+OFFSET_BITS+INDEX_BITS-1 : 2+OFFSET_BITS]; word = addr[2+OFFSET_BITS-1:2].
- Storage per line: valid bit, tag, 2**OFFSET_BITS data words.
- Reset (rst=0 at posedge):
  - All valid bits cleared; state goes to IDLE.
  - ic_rdy=0, ins=0, mc_ask=0, mc_addr=0.
  - Reset takes effect in every state, including mid-refill; a pending mc_rdy after reset is ignored.
- ic_rdy defaults to 0 every cycle; it is 1 only in the single response cycle.
- State IDLE:
  - On ins_asked=1 and flush=0, latch ins_addr into req_addr.
  - Hit (valid and tag match): next cycle drive ic_rdy=1 and ins = stored word; stay IDLE. Hit latency is exactly 1 cycle.
  - Miss: go to REFILL. Clear valid[index]. Set fill counter = 0. Assert mc_ask=1 and mc_addr = {tag, index, 0, 2'b00}.
- While a request is outstanding (REFILL or RESPOND), ins_asked is ignored. The fetcher holds ins_asked and re-requests after ic_rdy.
- State REFILL:
  - mc_ask stays high with a stable mc_addr until mc_rdy=1.
  - On mc_rdy: write mc_data into data[index][fill counter]; drop mc_ask for one cycle; increment the counter.
  - If the counter was not the last word: next cycle reassert mc_ask with mc_addr+4.
  - On the last word: write the tag, set valid, go to RESPOND.
  - Refill always starts at word 0 (no critical-word-first).
- State RESPOND: drive ic_rdy=1 and ins = data[req index][req word] (read from line storage, or forwarded from the just-written word); return to IDLE.
- flush:
  - In IDLE, flush=1 blocks acceptance that cycle.
  - During REFILL, the refill continues to completion and the line is installed, but the response is suppressed: RESPOND emits ic_rdy=0 and goes to IDLE.
  - flush coincident with an ic_rdy cycle does not cancel that pulse (fetcher discards it).
- rdy=0: no state, counter, array or output change; mc_rdy arriving while rdy=0 is lost. The memory controller shares rdy, so this does not occur in the system.
- Arithmetic:
  - mc_addr increments by 4 with no carry into the index/tag bits, because the counter wraps inside the line.
  - Address 0xFFFFFFFC is legal; tag is all ones.

Decomposition:
- Shared package (or header defines) holds the state encodings IDLE / REFILL / RESPOND and the address-split helper widths derived from INDEX_BITS/OFFSET_BITS.
- One natural sub-module: icache_line_array. It holds the valid/tag/data storage, with a synchronous write port (index, word, data, tag_we) and a combinational read port (index → valid, tag, word mux).
- The FSM and memory-controller handshake stay in instruction_cache.

Test Plan:
- Cold miss:
  - Stimulus: after reset, ins_asked with ins_addr=0x00000000; memory returns 0x00000013, 0x00100093, 0x00200113, 0x00300193 for 0x0/0x4/0x8/0xC, each mc_rdy 3 cycles after mc_ask.
  - Required: mc_addr sequence 0x0, 0x4, 0x8, 0xC; exactly 4 mc_ask phases; ic_rdy for one cycle with ins=0x00000013.
- Hit:
  - Stimulus: ins_addr=0x00000008 after the cold-miss line is installed.
  - Required: ic_rdy the next cycle, ins=0x00200113, mc_ask stays 0.
- Conflict eviction:
  - Stimulus: request 0x00000400 (same index 0, different tag), then 0x00000000.
  - Required: both miss and refill; 0x0 returns 0x00000013 again after its refill.
- Flush mid-refill:
  - Stimulus: miss at 0x00000040, flush=1 after the second mc_rdy.
  - Required: all 4 words fetched; no ic_rdy; a later request to 0x00000044 hits with 1-cycle latency.
- Reset mid-refill:
  - Stimulus: rst=0 during REFILL at word 2, then rst=1 and request 0x00000000.
  - Required: mc_ask=0 and ic_rdy=0 during reset; the request misses (valid cleared) and refills from 0x0.
- rdy stall:
  - Stimulus: rdy=0 for 5 cycles during a hit response window.
  - Required: ic_rdy is delayed exactly 5 cycles, is still a single pulse, and ins is unchanged.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default
// geometry, FSM state encoding and address-split width helpers.
package instruction_cache_pkg;

  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } ic_state_e;

  // Tag width left over once byte, word-offset and index bits are removed.
  function automatic int tag_bits(input int index_bits, input int offset_bits);
    return 32 - 2 - offset_bits - index_bits;
  endfunction

  // Lowest address bit of the line index field.
  function automatic int index_lsb(input int offset_bits);
    return 2 + offset_bits;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: per-line valid bit and tag plus
// the data words. Synchronous write port, combinational read port.
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int TAG_BITS    = tag_bits(DEF_INDEX_BITS, DEF_OFFSET_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  // invalidate one line (start of a refill)
  input  logic                   inv_we,
  input  logic [INDEX_BITS-1:0]  inv_index,
  // refill write port
  input  logic                   data_we,
  input  logic                   tag_we,
  input  logic [INDEX_BITS-1:0]  w_index,
  input  logic [OFFSET_BITS-1:0] w_word,
  input  logic [31:0]            w_data,
  input  logic [TAG_BITS-1:0]    w_tag,
  // lookup port
  input  logic [INDEX_BITS-1:0]  r_index,
  input  logic [OFFSET_BITS-1:0] r_word,
  output logic                   r_valid,
  output logic [TAG_BITS-1:0]    r_tag,
  output logic [31:0]            r_data
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int WORDS = 2 ** OFFSET_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES*WORDS];

  // Next valid vector: invalidate on refill start, set when the tag is installed.
  always_comb begin
    valid_d = valid_q;
    if (inv_we) begin
      valid_d[inv_index] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (tag_we) begin
      valid_d[w_index] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Valid bits are the only storage that must clear on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays behave as plain write-enabled memories.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[{w_index, w_word}] <= w_data;
    end
    if (tag_we) begin
      tag_q[w_index] <= w_tag;
    end
  end

  assign r_valid = valid_q[r_index];
  assign r_tag   = tag_q[r_index];
  assign r_data  = data_q[{r_index, r_word}];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after the
// request is sampled; misses refill the whole line from word 0 through the
// memory controller, then answer unless a flush made the request obsolete.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ins_asked,
  input  logic [31:0] ins_addr,
  output logic        ic_rdy,
  output logic [31:0] ins,
  input  logic        flush,
  output logic        mc_ask,
  output logic [31:0] mc_addr,
  input  logic        mc_rdy,
  input  logic [31:0] mc_data
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int IDX_LSB  = index_lsb(OFFSET_BITS);
  localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;

  ic_state_e                state_q, state_d;
  logic [31:2]              req_addr_q, req_addr_d;
  logic [OFFSET_BITS-1:0]   fill_cnt_q, fill_cnt_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     ic_rdy_q, ic_rdy_d;
  logic [31:0]              ins_q, ins_d;
  logic                     mc_ask_q, mc_ask_d;
  logic [31:0]              mc_addr_q, mc_addr_d;

  logic [TAG_BITS-1:0]      ins_tag_s, req_tag_s, arr_tag_s;
  logic [INDEX_BITS-1:0]    ins_idx_s, req_idx_s, rd_idx_s;
  logic [OFFSET_BITS-1:0]   ins_word_s, req_word_s, rd_word_s;
  logic                     arr_valid_s, hit_s, accept_s, mc_take_s, last_s;
  logic [31:0]              arr_data_s;
  logic                     inv_we_s, data_we_s, tag_we_s;
  logic [1:0]               unused_addr_s;

  assign ins_tag_s     = ins_addr[31:TAG_LSB];
  assign ins_idx_s     = ins_addr[TAG_LSB-1:IDX_LSB];
  assign ins_word_s    = ins_addr[IDX_LSB-1:2];
  assign req_tag_s     = req_addr_q[31:TAG_LSB];
  assign req_idx_s     = req_addr_q[TAG_LSB-1:IDX_LSB];
  assign req_word_s    = req_addr_q[IDX_LSB-1:2];
  assign unused_addr_s = ins_addr[1:0];

  // Lookups use the live fetch address while idle, the latched one otherwise.
  assign rd_idx_s  = (state_q == IDLE) ? ins_idx_s  : req_idx_s;
  assign rd_word_s = (state_q == IDLE) ? ins_word_s : req_word_s;

  assign hit_s     = arr_valid_s && (arr_tag_s == ins_tag_s);
  assign accept_s  = ins_asked && !flush;
  assign mc_take_s = mc_ask_q && mc_rdy;
  assign last_s    = (fill_cnt_q == {OFFSET_BITS{1'b1}});

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .inv_we   (inv_we_s),
    .inv_index(ins_idx_s),
    .data_we  (data_we_s),
    .tag_we   (tag_we_s),
    .w_index  (req_idx_s),
    .w_word   (fill_cnt_q),
    .w_data   (mc_data),
    .w_tag    (req_tag_s),
    .r_index  (rd_idx_s),
    .r_word   (rd_word_s),
    .r_valid  (arr_valid_s),
    .r_tag    (arr_tag_s),
    .r_data   (arr_data_s)
  );

  // State register plus all registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_addr_q   <= 30'd0;
      fill_cnt_q   <= {OFFSET_BITS{1'b0}};
      flush_pend_q <= 1'b0;
      ic_rdy_q     <= 1'b0;
      ins_q        <= 32'd0;
      mc_ask_q     <= 1'b0;
      mc_addr_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
      ic_rdy_q     <= ic_rdy_d;
      ins_q        <= ins_d;
      mc_ask_q     <= mc_ask_d;
      mc_addr_q    <= mc_addr_d;
    end
  end

  // Next state, request latch, fill counter and pending-flush tracking.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    fill_cnt_d   = fill_cnt_q;
    flush_pend_d = flush_pend_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            req_addr_d   = ins_addr[31:2];
            flush_pend_d = 1'b0;
            if (hit_s) begin
              state_d = IDLE;
            end else begin
              state_d    = REFILL;
              fill_cnt_d = {OFFSET_BITS{1'b0}};
            end
          end else begin
            state_d = IDLE;
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pend_d = 1'b1;
          end else begin
            flush_pend_d = flush_pend_q;
          end
          if (mc_take_s) begin
            fill_cnt_d = fill_cnt_q + OFFSET_BITS'(1);
            if (last_s) begin
              state_d = RESPOND;
            end else begin
              state_d = REFILL;
            end
          end else begin
            state_d = REFILL;
          end
        end
        RESPOND: begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output and array-write decode; everything holds while rdy is low.
  always_comb begin
    ic_rdy_d  = ic_rdy_q;
    ins_d     = ins_q;
    mc_ask_d  = mc_ask_q;
    mc_addr_d = mc_addr_q;
    inv_we_s  = 1'b0;
    data_we_s = 1'b0;
    tag_we_s  = 1'b0;
    if (rdy) begin
      ic_rdy_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s && hit_s) begin
            ic_rdy_d = 1'b1;
            ins_d    = arr_data_s;
          end else if (accept_s) begin
            inv_we_s  = 1'b1;
            mc_ask_d  = 1'b1;
            mc_addr_d = {ins_addr[31:IDX_LSB], {OFFSET_BITS{1'b0}}, 2'b00};
          end else begin
            ic_rdy_d = 1'b0;
          end
        end
        REFILL: begin
          if (mc_take_s) begin
            data_we_s = 1'b1;
            mc_ask_d  = 1'b0;
            tag_we_s  = last_s;
          end else if (!mc_ask_q) begin
            // Counter wraps inside the line, so the next word never carries
            // into the index or tag bits.
            mc_ask_d  = 1'b1;
            mc_addr_d = {mc_addr_q[31:IDX_LSB], fill_cnt_q, 2'b00};
          end else begin
            mc_ask_d = 1'b1;
          end
        end
        RESPOND: begin
          if (flush_pend_q || flush) begin
            ic_rdy_d = 1'b0;
          end else begin
            ic_rdy_d = 1'b1;
            ins_d    = arr_data_s;
          end
        end
        default: begin
          ic_rdy_d = 1'b0;
        end
      endcase
    end else begin
      ic_rdy_d = ic_rdy_q;
    end
  end

  assign ic_rdy  = ic_rdy_q;
  assign ins     = ins_q;
  assign mc_ask  = mc_ask_q;
  assign mc_addr = mc_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus pushes expected
// instruction words and refill addresses; monitors pop and compare.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, ins_asked, flush, mc_rdy;
  logic [31:0] ins_addr, mc_data;
  logic        ic_rdy, mc_ask;
  logic [31:0] ins, mc_addr;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int ask_cnt = 0;
  int mrdy_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  instruction_cache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .ins_asked(ins_asked),
    .ins_addr (ins_addr),
    .ic_rdy   (ic_rdy),
    .ins      (ins),
    .flush    (flush),
    .mc_ask   (mc_ask),
    .mc_addr  (mc_addr),
    .mc_rdy   (mc_rdy),
    .mc_data  (mc_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      32'h0000_000C: return 32'h0030_0193;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory controller model: answers each ask three cycles later
  initial begin
    int wcnt;
    wcnt = 0;
    mc_rdy = 1'b0;
    mc_data = 32'd0;
    forever begin
      @(negedge clk);
      mc_rdy = 1'b0;
      if (mc_ask === 1'b1 && rst && rdy) begin
        wcnt++;
        if (wcnt == 3) begin
          mc_rdy = 1'b1;
          mc_data = mem_word(mc_addr);
          mrdy_cnt++;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // response monitor
  initial begin
    logic prev_ic;
    prev_ic = 1'b0;
    forever begin
      @(negedge clk);
      if (ic_rdy === 1'b1 && rst) begin
        resp_cnt++;
        chk("ic_rdy_single_pulse", {31'd0, prev_ic}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ic_rdy", 32'd1, 32'd0);
        end else begin
          chk("ins", ins, exp_q.pop_front());
        end
      end
      prev_ic = ic_rdy;
    end
  end

  // refill request monitor
  initial begin
    logic        prev_ask;
    logic [31:0] last_addr;
    prev_ask = 1'b0;
    last_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (mc_ask === 1'b1 && !prev_ask) begin
        ask_cnt++;
        if (addr_q.size() == 0) begin
          chk("unexpected_mc_ask", mc_addr, 32'hFFFF_FFFF);
        end else begin
          chk("mc_addr", mc_addr, addr_q.pop_front());
        end
      end else if (mc_ask === 1'b1) begin
        chk("mc_addr_stable", mc_addr, last_addr);
      end
      prev_ask = mc_ask;
      last_addr = mc_addr;
    end
  end

  task automatic push_refill(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_resp(input int r0, input string name);
    for (int c = 0; c < 200 && resp_cnt == r0; c++) begin
      @(negedge clk);
      #1;
    end
    chk(name, resp_cnt, r0 + 1);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] exp, input bit hit);
    int a0, r0;
    a0 = ask_cnt;
    r0 = resp_cnt;
    exp_q.push_back(exp);
    if (!hit) push_refill(a);
    @(negedge clk);
    ins_asked = 1'b1;
    ins_addr = a;
    @(negedge clk);
    ins_asked = 1'b0;
    #1;
    if (hit) chk("hit_latency", {31'd0, ic_rdy}, 32'd1);
    wait_resp(r0, "response_seen");
    chk(hit ? "hit_no_mc_ask" : "miss_ask_phases", ask_cnt - a0, hit ? 32'd0 : 32'd4);
  endtask

  task automatic wait_mrdy(input int target);
    for (int c = 0; c < 200 && mrdy_cnt < target; c++) begin
      @(negedge clk);
      #1;
    end
    chk("mc_rdy_count", mrdy_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int a0, r0, m0;
    rst = 1'b0;
    rdy = 1'b1;
    ins_asked = 1'b0;
    ins_addr = 32'd0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ic_rdy", {31'd0, ic_rdy}, 32'd0);
    chk("reset_ins", ins, 32'd0);
    chk("reset_mc_ask", {31'd0, mc_ask}, 32'd0);
    chk("reset_mc_addr", mc_addr, 32'd0);
    rst = 1'b1;

    // cold miss, hit, conflict eviction
    do_req(32'h0000_0000, 32'h0000_0013, 1'b0);
    do_req(32'h0000_0008, 32'h0020_0113, 1'b1);
    do_req(32'h0000_0400, 32'h5A5A_0400, 1'b0);
    do_req(32'h0000_0000, 32'h0000_0013, 1'b0);

    // flush in IDLE blocks acceptance
    a0 = ask_cnt;
    r0 = resp_cnt;
    @(negedge clk);
    ins_asked = 1'b1;
    ins_addr = 32'h0000_0008;
    flush = 1'b1;
    @(negedge clk);
    ins_asked = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_flush_no_resp", resp_cnt, r0);
    chk("idle_flush_no_ask", ask_cnt, a0);

    // flush mid-refill: line installed, no response
    a0 = ask_cnt;
    r0 = resp_cnt;
    m0 = mrdy_cnt;
    push_refill(32'h0000_0040);
    @(negedge clk);
    ins_asked = 1'b1;
    ins_addr = 32'h0000_0040;
    @(negedge clk);
    ins_asked = 1'b0;
    wait_mrdy(m0 + 2);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_mrdy(m0 + 4);
    repeat (6) @(negedge clk);
    #1;
    chk("flush_no_resp", resp_cnt, r0);
    chk("flush_all_words", ask_cnt - a0, 32'd4);
    do_req(32'h0000_0044, 32'h5A5A_0044, 1'b1);

    // reset mid-refill at word 2
    m0 = mrdy_cnt;
    push_refill(32'h0000_0010);
    @(negedge clk);
    ins_asked = 1'b1;
    ins_addr = 32'h0000_0010;
    @(negedge clk);
    ins_asked = 1'b0;
    wait_mrdy(m0 + 2);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_mc_ask", {31'd0, mc_ask}, 32'd0);
      chk("rst_ic_rdy", {31'd0, ic_rdy}, 32'd0);
    end
    addr_q.delete();
    rst = 1'b1;
    do_req(32'h0000_0000, 32'h0000_0013, 1'b0);

    // rdy stall during a hit
    r0 = resp_cnt;
    exp_q.push_back(32'h0010_0093);
    @(negedge clk);
    rdy = 1'b0;
    ins_asked = 1'b1;
    ins_addr = 32'h0000_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_no_ic_rdy", {31'd0, ic_rdy}, 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    ins_asked = 1'b0;
    #1;
    chk("stall_hit_after_5", {31'd0, ic_rdy}, 32'd1);
    chk("stall_ins", ins, 32'h0010_0093);
    @(negedge clk);
    #1;
    chk("stall_pulse_ended", {31'd0, ic_rdy}, 32'd0);
    chk("stall_one_resp", resp_cnt, r0 + 1);

    // top-of-memory address: all-ones tag, last index, last word
    do_req(32'hFFFF_FFFC, 32'hA5A5_FFFC, 1'b0);
    do_req(32'hFFFF_FFF0, 32'hA5A5_FFF0, 1'b1);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("addr_q_drained", addr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
